// File: rtl/arm_regfile_pkg.sv
// Purpose: shared mode encodings, physical register indices and bank lookup for the banked register file.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package arm_regfile_pkg;

  // CPSR mode field encodings
  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  // Physical layout: 0..7 shared, 8..12 USR R8-R12, 13..17 FIQ R8-R12,
  // 18..29 R13/R14 pairs per bank, 30 is the PC
  localparam int NUM_PHYS = 31;
  localparam int NUM_GPR  = 30;

  localparam logic [4:0] P_R8_USR  = 5'd8;
  localparam logic [4:0] P_R8_FIQ  = 5'd13;
  localparam logic [4:0] P_R13_USR = 5'd18;
  localparam logic [4:0] P_R14_USR = 5'd19;
  localparam logic [4:0] P_R13_FIQ = 5'd20;
  localparam logic [4:0] P_R14_FIQ = 5'd21;
  localparam logic [4:0] P_R13_IRQ = 5'd22;
  localparam logic [4:0] P_R14_IRQ = 5'd23;
  localparam logic [4:0] P_R13_SVC = 5'd24;
  localparam logic [4:0] P_R14_SVC = 5'd25;
  localparam logic [4:0] P_R13_ABT = 5'd26;
  localparam logic [4:0] P_R14_ABT = 5'd27;
  localparam logic [4:0] P_R13_UND = 5'd28;
  localparam logic [4:0] P_R14_UND = 5'd29;
  localparam logic [4:0] P_PC      = 5'd30;

  // Bank order matches the R13/R14 pair order above (pair base = P_R13_USR + 2*bank)
  typedef enum logic [2:0] {
    BANK_USR = 3'd0,
    BANK_FIQ = 3'd1,
    BANK_IRQ = 3'd2,
    BANK_SVC = 3'd3,
    BANK_ABT = 3'd4,
    BANK_UND = 3'd5
  } bank_e;

  // SYS and any unrecognised encoding fall back to the USR bank
  function automatic bank_e mode_bank(input logic [4:0] mode);
    case (mode)
      MODE_FIQ: return BANK_FIQ;
      MODE_IRQ: return BANK_IRQ;
      MODE_SVC: return BANK_SVC;
      MODE_ABT: return BANK_ABT;
      MODE_UND: return BANK_UND;
      default:  return BANK_USR;
    endcase
  endfunction

endpackage

// File: rtl/arm_banked_regfile_if.sv
// Purpose: decode/writeback/fetch side bundle of the banked register file.
// Latency: n/a (wires only).
// Backpressure: none; the register file accepts every read and write each cycle.
interface arm_banked_regfile_if #(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 3
);
  logic [4:0]             mode;
  logic [4*NUM_RD-1:0]    rd_addr;
  logic [DATA_W*NUM_RD-1:0] rd_data;
  logic                   wr_en;
  logic [3:0]             wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   wr_user;
  logic                   pc_inc;
  logic [DATA_W-1:0]      pc_out;

  modport master (
    output mode, rd_addr, wr_en, wr_addr, wr_data, wr_user, pc_inc,
    input  rd_data, pc_out
  );

  modport slave (
    input  mode, rd_addr, wr_en, wr_addr, wr_data, wr_user, pc_inc,
    output rd_data, pc_out
  );
endinterface

// File: rtl/arm_reg_bank_map.sv
// Purpose: map a logical register number plus CPSR mode onto a physical register index.
// Latency: combinational, 0 cycles.
// Backpressure: none.
module arm_reg_bank_map
  import arm_regfile_pkg::*;
(
  input  logic [3:0] log_addr,
  input  logic [4:0] mode,
  output logic [4:0] phys_idx
);

  bank_e bank;

  // R0-R7 pass through, R8-R12 bank only for FIQ, R13/R14 bank per mode, R15 is the PC
  always_comb begin
    bank     = mode_bank(mode);
    phys_idx = {1'b0, log_addr};
    if (log_addr == 4'd15) begin
      phys_idx = P_PC;
    end else if (log_addr >= 4'd13) begin
      // R13 has bit0=1 -> offset 0, R14 has bit0=0 -> offset 1
      phys_idx = P_R13_USR + {1'b0, bank, 1'b0} + {4'b0000, ~log_addr[0]};
    end else if (log_addr >= 4'd8 && bank == BANK_FIQ) begin
      phys_idx = P_R8_FIQ + {1'b0, log_addr} - P_R8_USR;
    end
  end

endmodule

// File: rtl/arm_banked_regfile.sv
// Purpose: ARM7TDMI banked integer register file with integrated PC and same-cycle write forwarding.
// Latency: reads combinational (0 cycles); writes and PC updates land on the next rising edge.
// Backpressure: none; every read and write is serviced every cycle.
module arm_banked_regfile
  import arm_regfile_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                NUM_RD      = 3,
  parameter logic [DATA_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] PC_READ_OFS = DATA_W'(8)
) (
  input  logic               clock,
  input  logic               reset_n,
  arm_banked_regfile_if.slave bus
);

  logic [DATA_W-1:0]        gpr_q [NUM_GPR];
  logic [DATA_W-1:0]        gpr_d [NUM_GPR];
  logic [DATA_W-1:0]        pc_q;
  logic [DATA_W-1:0]        pc_d;
  logic [4:0]               wr_mode;
  logic [4:0]               wr_phys;
  logic [4:0]               rd_phys [NUM_RD];
  logic                     fwd_en;
  logic [DATA_W*NUM_RD-1:0] rd_data_c;

  // USR-forced writes (LDM/STM with ^) take the USR mapping; reads never do
  assign wr_mode = bus.wr_user ? MODE_USR : bus.mode;

  arm_reg_bank_map u_wr_map (
    .log_addr (bus.wr_addr),
    .mode     (wr_mode),
    .phys_idx (wr_phys)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_map
    arm_reg_bank_map u_rd_map (
      .log_addr (bus.rd_addr[4*k +: 4]),
      .mode     (bus.mode),
      .phys_idx (rd_phys[k])
    );
  end

  // Next-state for the GPR array: the single write port updates one physical entry
  always_comb begin
    gpr_d = gpr_q;
    if (bus.wr_en && wr_phys != P_PC) begin
      gpr_d[wr_phys] = bus.wr_data;
    end
  end

  // Next PC: an R15 write beats the sequential increment, otherwise hold
  always_comb begin
    pc_d = pc_q;
    if (bus.wr_en && wr_phys == P_PC) begin
      pc_d = {bus.wr_data[DATA_W-1:2], 2'b00};
    end else if (bus.pc_inc) begin
      pc_d = pc_q + DATA_W'(4);
    end
  end

  // Storage and PC registers; a write coincident with reset is dropped
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gpr_q <= '{default: '0};
      pc_q  <= RESET_PC;
    end else begin
      gpr_q <= gpr_d;
      pc_q  <= pc_d;
    end
  end

  // Forwarding is held off in reset so reads report the cleared state
  assign fwd_en = bus.wr_en && reset_n;

  // Per-port read mux: R15 gives offset PC, matching physical write forwards, else storage
  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_phys[k] == P_PC) begin
        rd_data_c[DATA_W*k +: DATA_W] = pc_q + PC_READ_OFS;
      end else if (fwd_en && rd_phys[k] == wr_phys) begin
        rd_data_c[DATA_W*k +: DATA_W] = bus.wr_data;
      end else begin
        rd_data_c[DATA_W*k +: DATA_W] = gpr_q[rd_phys[k]];
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.pc_out  = pc_q;

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Purpose: directed check of banking, USR-forced writes, forwarding, PC update and reset.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_arm_banked_regfile;
  import arm_regfile_pkg::*;

  logic clock;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;

  arm_banked_regfile_if #(.DATA_W(32), .NUM_RD(3)) bus ();

  arm_banked_regfile #(
    .DATA_W      (32),
    .NUM_RD      (3),
    .RESET_PC    (32'h0000_0000),
    .PC_READ_OFS (32'd8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  typedef struct {
    logic [4:0]  mode;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        wu;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    bus.rd_addr = {a2, a1, a0};
  endtask

  function automatic logic [31:0] rd(input int k);
    logic [95:0] all;
    all = bus.rd_data;
    return all[32*k +: 32];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // mode, we, wa, wd, wu, ra0, ra1, ra2, e0, e1, e2
    vecs[0]  = '{MODE_USR, 1'b1, 4'd13, 32'h1111_0000, 1'b0, 4'd13, 4'd0,  4'd15, 32'h1111_0000, 32'h0, 32'h8};
    vecs[1]  = '{MODE_IRQ, 1'b1, 4'd13, 32'h2222_0000, 1'b0, 4'd13, 4'd14, 4'd15, 32'h2222_0000, 32'h0, 32'h8};
    vecs[2]  = '{MODE_IRQ, 1'b0, 4'd0,  32'h0,         1'b0, 4'd13, 4'd14, 4'd0,  32'h2222_0000, 32'h0, 32'h0};
    vecs[3]  = '{MODE_USR, 1'b0, 4'd0,  32'h0,         1'b0, 4'd13, 4'd14, 4'd15, 32'h1111_0000, 32'h0, 32'h8};
    vecs[4]  = '{MODE_SYS, 1'b0, 4'd0,  32'h0,         1'b0, 4'd13, 4'd14, 4'd12, 32'h1111_0000, 32'h0, 32'h0};
    vecs[5]  = '{MODE_FIQ, 1'b1, 4'd8,  32'hA5A5_A5A5, 1'b0, 4'd8,  4'd9,  4'd13, 32'hA5A5_A5A5, 32'h0, 32'h0};
    vecs[6]  = '{MODE_USR, 1'b0, 4'd0,  32'h0,         1'b0, 4'd8,  4'd9,  4'd13, 32'h0, 32'h0, 32'h1111_0000};
    vecs[7]  = '{MODE_FIQ, 1'b0, 4'd0,  32'h0,         1'b0, 4'd8,  4'd13, 4'd14, 32'hA5A5_A5A5, 32'h0, 32'h0};
    vecs[8]  = '{MODE_FIQ, 1'b1, 4'd7,  32'h0000_0777, 1'b0, 4'd7,  4'd8,  4'd0,  32'h777, 32'hA5A5_A5A5, 32'h0};
    vecs[9]  = '{MODE_SVC, 1'b0, 4'd0,  32'h0,         1'b0, 4'd7,  4'd8,  4'd13, 32'h777, 32'h0, 32'h0};
    vecs[10] = '{MODE_SVC, 1'b1, 4'd14, 32'hDEAD_BEEF, 1'b1, 4'd14, 4'd13, 4'd7,  32'h0, 32'h0, 32'h777};
    vecs[11] = '{MODE_SVC, 1'b0, 4'd0,  32'h0,         1'b0, 4'd14, 4'd13, 4'd15, 32'h0, 32'h0, 32'h8};
    vecs[12] = '{MODE_USR, 1'b0, 4'd0,  32'h0,         1'b0, 4'd14, 4'd13, 4'd7,  32'hDEAD_BEEF, 32'h1111_0000, 32'h777};
    vecs[13] = '{MODE_FIQ, 1'b1, 4'd8,  32'h0BAD_CAFE, 1'b1, 4'd8,  4'd14, 4'd15, 32'hA5A5_A5A5, 32'h0, 32'h8};
    vecs[14] = '{MODE_USR, 1'b0, 4'd0,  32'h0,         1'b0, 4'd8,  4'd14, 4'd13, 32'h0BAD_CAFE, 32'hDEAD_BEEF, 32'h1111_0000};
    vecs[15] = '{MODE_USR, 1'b1, 4'd3,  32'h1234_5678, 1'b0, 4'd0,  4'd3,  4'd15, 32'h0, 32'h1234_5678, 32'h8};
    vecs[16] = '{MODE_ABT, 1'b0, 4'd0,  32'h0,         1'b0, 4'd3,  4'd13, 4'd14, 32'h1234_5678, 32'h0, 32'h0};
    vecs[17] = '{MODE_UND, 1'b1, 4'd13, 32'h5555_0001, 1'b0, 4'd13, 4'd14, 4'd3,  32'h5555_0001, 32'h0, 32'h1234_5678};
    vecs[18] = '{5'b00000, 1'b0, 4'd0,  32'h0,         1'b0, 4'd13, 4'd14, 4'd8,  32'h1111_0000, 32'hDEAD_BEEF, 32'h0BAD_CAFE};
    vecs[19] = '{MODE_UND, 1'b0, 4'd0,  32'h0,         1'b0, 4'd13, 4'd14, 4'd0,  32'h5555_0001, 32'h0, 32'h0};

    // initial power-on reset
    reset_n      = 1'b0;
    bus.mode     = MODE_USR;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = 4'd0;
    bus.wr_data  = 32'h0;
    bus.wr_user  = 1'b0;
    bus.pc_inc   = 1'b0;
    set_rd(4'd0, 4'd0, 4'd15);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // move PC off its reset value so the mid-cycle reset is observable
    bus.pc_inc = 1'b1;
    @(posedge clock); #1;
    bus.pc_inc = 1'b0;
    chk("pc_before_reset", bus.pc_out, 32'h4);

    // assert reset mid-cycle while a write to R3 is being presented
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd3;
    bus.wr_data = 32'hFFFF_FFFF;
    set_rd(4'd3, 4'd0, 4'd15);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_pc_out", bus.pc_out, 32'h0);
    chk("reset_r3_no_fwd", rd(0), 32'h0);
    chk("reset_r15_read", rd(2), 32'h8);
    for (int a = 0; a < 15; a++) begin
      set_rd(4'(a), 4'd0, 4'd15);
      #1;
      chk($sformatf("reset_r%0d", a), rd(0), 32'h0);
    end
    @(posedge clock); #1;
    bus.wr_en = 1'b0;
    #1 reset_n = 1'b1;
    set_rd(4'd3, 4'd0, 4'd15);
    @(posedge clock); #1;
    chk("reset_write_lost", rd(0), 32'h0);
    chk("post_reset_pc", bus.pc_out, 32'h0);

    // table-driven banking / forwarding vectors, one cycle each
    for (int i = 0; i < NV; i++) begin
      bus.mode    = vecs[i].mode;
      bus.wr_en   = vecs[i].we;
      bus.wr_addr = vecs[i].wa;
      bus.wr_data = vecs[i].wd;
      bus.wr_user = vecs[i].wu;
      set_rd(vecs[i].ra0, vecs[i].ra1, vecs[i].ra2);
      @(negedge clock);
      chk($sformatf("vec%0d_port0", i), rd(0), vecs[i].e0);
      chk($sformatf("vec%0d_port1", i), rd(1), vecs[i].e1);
      chk($sformatf("vec%0d_port2", i), rd(2), vecs[i].e2);
      chk($sformatf("vec%0d_pc", i), bus.pc_out, 32'h0);
      @(posedge clock); #1;
    end
    bus.wr_en   = 1'b0;
    bus.wr_user = 1'b0;
    bus.mode    = MODE_USR;

    // PC: three increments from 0
    set_rd(4'd15, 4'd0, 4'd0);
    bus.pc_inc = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    bus.pc_inc = 1'b0;
    chk("pc_inc3", bus.pc_out, 32'h0000_000C);
    chk("pc_inc3_r15", rd(0), 32'h0000_0014);

    // R15 write wins over pc_inc and is not forwarded to the R15 read
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd15;
    bus.wr_data = 32'h0000_1003;
    bus.pc_inc  = 1'b1;
    #1;
    chk("r15_no_fwd", rd(0), 32'h0000_0014);
    @(posedge clock); #1;
    bus.wr_en  = 1'b0;
    bus.pc_inc = 1'b0;
    chk("pc_write_prio", bus.pc_out, 32'h0000_1000);
    chk("pc_write_r15", rd(0), 32'h0000_1008);

    // load PC near the top and wrap on increment
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'hFFFF_FFFC;
    @(posedge clock); #1;
    bus.wr_en = 1'b0;
    chk("pc_top", bus.pc_out, 32'hFFFF_FFFC);
    chk("pc_top_r15_wrap", rd(0), 32'h0000_0004);
    @(posedge clock); #1;
    chk("pc_hold", bus.pc_out, 32'hFFFF_FFFC);
    bus.pc_inc = 1'b1;
    @(posedge clock); #1;
    bus.pc_inc = 1'b0;
    chk("pc_wrap", bus.pc_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
